// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection default
// and the transfer FSM state type used by both master and slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WAIT_B,
    ST_RD_ADDR,
    ST_WAIT_R,
    ST_RSP
  } axi_state_e;

endpackage

// File: rtl/m_axi_lite_master.sv
// AXI4-Lite master: one write or read transfer per command, result and
// saturating latency returned on a held response port.
module m_axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int P_M_AXI_DATA_WIDTH = 32,
  parameter int P_M_AXI_ADDR_WIDTH = 4,
  parameter int P_LAT_WIDTH        = 8
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [1:0]                      rsp_resp,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [P_LAT_WIDTH-1:0]          rsp_latency,
  output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [P_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int DW = P_M_AXI_DATA_WIDTH;
  localparam int AW = P_M_AXI_ADDR_WIDTH;
  localparam int LW = P_LAT_WIDTH;

  axi_state_e        r_state;
  logic              r_cmd_ready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_aw_done;
  logic              r_w_done;
  logic              r_write;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW/8-1:0]   r_wstrb;
  logic [LW-1:0]     r_lat;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [1:0]        r_rsp_resp;
  logic [DW-1:0]     r_rsp_rdata;
  logic [LW-1:0]     r_rsp_latency;
  logic [LW-1:0]     w_lat_nxt;

  assign w_lat_nxt = (&r_lat) ? r_lat : r_lat + LW'(1);

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_aw_done     <= 1'b0;
      r_w_done      <= 1'b0;
      r_write       <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_lat         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_rdata   <= '0;
      r_rsp_latency <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            r_write     <= cmd_write;
            // the accept cycle itself is the first counted cycle
            r_lat       <= LW'(1);
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WR_ADDR_DATA;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_WR_ADDR_DATA: begin
          r_lat <= w_lat_nxt;
          if (r_awvalid && M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && M_AXI_WREADY) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (r_aw_done && r_w_done) begin
            r_bready <= 1'b1;
            r_state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          r_lat <= w_lat_nxt;
          if (M_AXI_BVALID) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_write;
            r_rsp_resp    <= M_AXI_BRESP;
            r_rsp_rdata   <= '0;
            r_rsp_latency <= w_lat_nxt;
            r_state       <= ST_RSP;
          end
        end
        ST_RD_ADDR: begin
          r_lat <= w_lat_nxt;
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_WAIT_R;
          end
        end
        ST_WAIT_R: begin
          r_lat <= w_lat_nxt;
          if (M_AXI_RVALID) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_write;
            r_rsp_resp    <= M_AXI_RRESP;
            r_rsp_rdata   <= M_AXI_RDATA;
            r_rsp_latency <= w_lat_nxt;
            r_state       <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_write     = r_rsp_write;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_latency   = r_rsp_latency;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_RREADY  = r_rready;

endmodule
